// File: rtl/cache_bus_sram_responder.sv
// cache_bus_sram_responder
//   Responder end of the cache_bus handshake. Accepts one address-phase request
//   at a time and serves single or wrapping burst reads/writes from an on-chip
//   word-addressed SRAM (boot / instruction scratchpad).
//
// Ports (cache_bus_req_t / cache_bus_resp_t fields, flattened):
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid           address phase valid
//   req_write           1 = write transaction
//   req_burst           0 = single beat, 1 = BURST_LEN beats
//   req_cached          ignored
//   req_addr            byte address; word index is addr[2 +: log2(DEPTH_WORDS)]
//   req_w_data          write beat data
//   req_data_strobe     write byte lane enables
//   req_data_ok         initiator ready/valid for the current beat
//   req_data_last       ignored (termination is by count)
//   resp_ready          address phase ready (IDLE only)
//   resp_r_data         read beat data (0 outside READ)
//   resp_data_ok        beat valid/ready (READ and WRITE)
//   resp_data_last      final beat of the transaction
//
// Configuration:
//   CACHE_BUS_RESP_WRITE_EN  defined: writes update the SRAM.
//                            undefined: write beats are handshaken and discarded
//                            (ROM behaviour); contents come only from the
//                            initialization image loaded into mem.
//
// SRAM contents are never cleared by reset.

module cache_bus_sram_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned BURST_LEN   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic        req_burst,
   input  logic        req_cached,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_w_data,
   input  logic [3:0]  req_data_strobe,
   input  logic        req_data_ok,
   input  logic        req_data_last,
   output logic        resp_ready,
   output logic [31:0] resp_r_data,
   output logic        resp_data_ok,
   output logic        resp_data_last
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned BW = $clog2(BURST_LEN);
   localparam int unsigned CW = BW + 1;
   localparam logic [AW-1:0] WRAP_MASK = AW'(BURST_LEN - 1);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] last_q, last_d;
   logic [AW-1:0] start_q, start_d;
   logic [31:0]   rdata_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept, xfer;
   logic          rd_en, wr_en;
   logic [AW-1:0] rd_idx, wr_idx;

   // Critical-word-first: offset wraps inside the BURST_LEN-aligned block.
   function automatic logic [AW-1:0] beat_idx(input logic [AW-1:0] start,
                                              input logic [CW-1:0] k);
      logic [AW-1:0] off;
      off = start + AW'(k);
      return (start & ~WRAP_MASK) | (off & WRAP_MASK);
   endfunction

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      last_d         = last_q;
      start_d        = start_q;
      resp_ready     = 1'b0;
      resp_data_ok   = 1'b0;
      resp_data_last = 1'b0;
      resp_r_data    = '0;
      rd_en          = 1'b0;
      rd_idx         = req_addr[2 +: AW];
      wr_en          = 1'b0;
      wr_idx         = beat_idx(start_q, cnt_q);
      // Handshakes are suppressed in reset so nothing commits on a reset edge.
      accept         = 1'b0;
      xfer           = 1'b0;

      unique case (state_q)
         StIdle: begin
            resp_ready = 1'b1;
            accept     = req_valid & rst_n;
            if (accept) begin
               cnt_d   = '0;
               start_d = req_addr[2 +: AW];
               last_d  = req_burst ? CW'(BURST_LEN - 1) : '0;
               if (req_write) begin
                  state_d = StWrite;
               end else begin
                  // Beat 0 read issued now so data is valid the next cycle.
                  state_d = StRead;
                  rd_en   = 1'b1;
               end
            end
         end
         StRead: begin
            resp_data_ok   = 1'b1;
            resp_r_data    = rdata_q;
            resp_data_last = (cnt_q == last_q);
            xfer           = req_data_ok & rst_n;
            if (xfer) begin
               if (resp_data_last) begin
                  state_d = StIdle;
               end else begin
                  rd_en  = 1'b1;
                  rd_idx = beat_idx(start_q, cnt_q + CW'(1));
                  cnt_d  = cnt_q + CW'(1);
               end
            end
         end
         StWrite: begin
            resp_data_ok   = 1'b1;
            resp_data_last = (cnt_q == last_q);
            xfer           = req_data_ok & rst_n;
            if (xfer) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (resp_data_last) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // All response fields read as zero while reset is held.
      if (!rst_n) begin
         resp_ready     = 1'b0;
         resp_data_ok   = 1'b0;
         resp_data_last = 1'b0;
         resp_r_data    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= '0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         start_q <= start_d;
      end
   end

   // Registered SRAM read port; holds its value while no read is issued.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rdata_q <= mem[rd_idx];
      end
   end

`ifdef CACHE_BUS_RESP_WRITE_EN
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (req_data_strobe[b]) begin
               mem[wr_idx][8*b +: 8] <= req_w_data[8*b +: 8];
            end
         end
      end
   end

   logic unused_sigs;
   assign unused_sigs = ^{req_cached, req_data_last, req_addr[1:0], req_addr[31:2+AW]};
`else
   logic unused_sigs;
   assign unused_sigs = ^{req_cached, req_data_last, req_addr[1:0], req_addr[31:2+AW],
                          req_w_data, req_data_strobe, wr_en, wr_idx};
`endif

endmodule

// File: tb/tb_cache_bus_sram_responder.sv
module tb_cache_bus_sram_responder;

   localparam int DEPTH = 4096;
   localparam int BL    = 8;
   localparam int AW    = 12;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_write, req_burst, req_cached;
   logic [31:0] req_addr, req_w_data;
   logic [3:0]  req_data_strobe;
   logic        req_data_ok, req_data_last;
   logic        resp_ready, resp_data_ok, resp_data_last;
   logic [31:0] resp_r_data;

   logic [31:0] model [DEPTH];
   int          n_checks;
   int          n_errors;

   cache_bus_sram_responder #(
      .DEPTH_WORDS(DEPTH),
      .BURST_LEN  (BL)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_burst      (req_burst),
      .req_cached     (req_cached),
      .req_addr       (req_addr),
      .req_w_data     (req_w_data),
      .req_data_strobe(req_data_strobe),
      .req_data_ok    (req_data_ok),
      .req_data_last  (req_data_last),
      .resp_ready     (resp_ready),
      .resp_r_data    (resp_r_data),
      .resp_data_ok   (resp_data_ok),
      .resp_data_last (resp_data_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      model[idx]   = val;
      dut.mem[idx] = val;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, {31'b0, resp_ready}, 32'd0);
      check({tag, "_data_ok"}, {31'b0, resp_data_ok}, 32'd0);
      check({tag, "_data_last"}, {31'b0, resp_data_last}, 32'd0);
      check({tag, "_r_data"}, resp_r_data, 32'd0);
   endtask

   // One transaction, called at a negedge with the responder idle. stall_mask bit c
   // drops req_data_ok on cycle c after the handshake. abort_beat >= 0 asserts reset
   // when that beat is current. Returns the last observed read beat.
   task automatic txn(input bit wr, input bit bst, input logic [31:0] addr, input int pct,
                      input logic [31:0] stall_mask, input int abort_beat,
                      input bit fix_w, input logic [31:0] fw_data, input logic [3:0] fw_strb,
                      output logic [31:0] last_rd);
      int  len, idx0, base, idx, k, cyc;
      bit  dok;
      logic [31:0] wd;
      logic [3:0]  st;
      len     = bst ? BL : 1;
      idx0    = int'(addr[2 +: AW]);
      base    = idx0 - (idx0 % len);
      last_rd = '0;
      check("ready_idle", {31'b0, resp_ready}, 32'd1);
      check("data_ok_idle", {31'b0, resp_data_ok}, 32'd0);
      req_valid   = 1'b1;
      req_write   = wr;
      req_burst   = bst;
      req_addr    = addr;
      req_cached  = 1'($urandom_range(1));
      req_data_ok = 1'($urandom_range(1));
      @(negedge clk);
      k   = 0;
      cyc = 1;
      while (k < len) begin
         if (k == abort_beat) begin
            rst_n       = 1'b0;
            req_valid   = 1'b0;
            req_data_ok = 1'b0;
            #1;
            check_all_zero("abort");
            return;
         end
         idx = base + ((idx0 + k) % len);
         check("busy_ready", {31'b0, resp_ready}, 32'd0);
         check("beat_data_ok", {31'b0, resp_data_ok}, 32'd1);
         check("beat_data_last", {31'b0, resp_data_last}, {31'b0, (k == len - 1)});
         check(wr ? "w_r_data_zero" : "r_data", resp_r_data, wr ? 32'd0 : model[idx]);
         last_rd = resp_r_data;
         dok = ($urandom_range(99) >= pct);
         if (cyc < 32 && stall_mask[cyc]) dok = 1'b0;
         if (cyc > 200) dok = 1'b1;
         wd = fix_w ? fw_data : $urandom;
         st = fix_w ? fw_strb : 4'($urandom_range(15));
         req_w_data      = wd;
         req_data_strobe = st;
         req_data_ok     = dok;
         req_data_last   = 1'($urandom_range(1));
         // Requests while busy must be ignored.
         req_valid = 1'($urandom_range(1));
         req_write = 1'($urandom_range(1));
         req_burst = 1'($urandom_range(1));
         req_addr  = $urandom;
         if (dok) begin
`ifdef CACHE_BUS_RESP_WRITE_EN
            if (wr) begin
               for (int b = 0; b < 4; b++) begin
                  if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
               end
            end
`endif
            k++;
         end
         cyc++;
         @(negedge clk);
      end
      req_valid   = 1'b0;
      req_data_ok = 1'b0;
      check("ready_after", {31'b0, resp_ready}, 32'd1);
      check("data_ok_after", {31'b0, resp_data_ok}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_rb;
      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      req_valid       = 1'b0;
      req_write       = 1'b0;
      req_burst       = 1'b0;
      req_cached      = 1'b0;
      req_addr        = '0;
      req_w_data      = '0;
      req_data_strobe = '0;
      req_data_ok     = 1'b0;
      req_data_last   = 1'b0;
      for (int i = 0; i < DEPTH; i++) poke(i, $urandom);

      // Reset values
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_post_reset", {31'b0, resp_ready}, 32'd1);

      // Single read
      poke(32'h40, 32'hDEADBEEF);
      txn(1'b0, 1'b0, 32'h100, 0, 32'h0, -1, 1'b0, 32'h0, 4'h0, rd);
      check("single_read", rd, 32'hDEADBEEF);

      // Wrapping burst read: 5,6,7,0,1,2,3,4
      for (int i = 0; i < 8; i++) poke(i, i);
      txn(1'b0, 1'b1, 32'h14, 0, 32'h0, -1, 1'b0, 32'h0, 4'h0, rd);
      check("wrap_last_beat", rd, 32'd4);

      // Backpressure on cycles 2-4 after the handshake
      txn(1'b0, 1'b1, 32'h14, 0, 32'h1C, -1, 1'b0, 32'h0, 4'h0, rd);
      check("stall_last_beat", rd, 32'd4);

      // Strobed write then read-back at L+1
      poke(32'h10, 32'h11223344);
      txn(1'b1, 1'b0, 32'h40, 0, 32'h0, -1, 1'b1, 32'hAABBCCDD, 4'b0101, rd);
      txn(1'b0, 1'b0, 32'h40, 0, 32'h0, -1, 1'b0, 32'h0, 4'h0, rd);
`ifdef CACHE_BUS_RESP_WRITE_EN
      exp_rb = 32'h11BB33DD;
`else
      exp_rb = 32'h11223344;
`endif
      check("strobe_readback", rd, exp_rb);

      // Reset during beat 3 of a read burst
      txn(1'b0, 1'b1, 32'h0, 0, 32'h0, 3, 1'b0, 32'h0, 4'h0, rd);
      repeat (2) begin
         @(negedge clk);
         check_all_zero("in_reset");
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_abort", {31'b0, resp_ready}, 32'd1);
      txn(1'b0, 1'b0, 32'h104, 0, 32'h0, -1, 1'b0, 32'h0, 4'h0, rd);
      check("read_after_abort", rd, model[32'h41]);

      // Write burst (discarded without the write macro), then read-back
      txn(1'b1, 1'b1, 32'h208, 20, 32'h0, -1, 1'b0, 32'h0, 4'h0, rd);
      txn(1'b0, 1'b1, 32'h208, 20, 32'h0, -1, 1'b0, 32'h0, 4'h0, rd);

      // Randomized traffic, addresses alias over the full 32-bit range
      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         a = (t % 3 == 0) ? ($urandom & 32'h0000_00FC) | ($urandom & 32'hFFFF_0000) : $urandom;
         txn(1'($urandom_range(1)), 1'($urandom_range(1)), a, 30, 32'h0, -1,
             1'b0, 32'h0, 4'h0, rd);
         if ($urandom_range(3) == 0) begin
            repeat ($urandom_range(3)) @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_bus_sram_responder.md
# cache_bus_sram_responder

Responder end of the cache_bus handshake: accepts address-phase requests from an initiator (icache, dcache, uncached fetch path) and serves single or burst reads and writes from an on-chip word-addressed SRAM. Used as boot/instruction scratchpad and as the bus-side model that initiators are verified against. It drives `cache_bus_resp_t` and consumes `cache_bus_req_t`, with the same field semantics the initiators use.

## Interface
- `DEPTH_WORDS`, default 4096: SRAM depth in 32-bit words; power of two.
- `BURST_LEN`, default 8: beats in a burst transaction; power of two, at least 2.
- `clk`  in  1: clock.
- `rst_n`  in  1: synchronous reset, active low. Sampled on `posedge clk`.
- `bus_req_i`  in  `cache_bus_req_t`: fields used are `valid`, `write`, `burst`, `addr`, `w_data`, `data_strobe`, `data_ok`, `data_last`. `cached` is ignored.
- `bus_resp_o`  out  `cache_bus_resp_t`: fields driven are `ready`, `r_data`, `data_ok`, `data_last`.

## Operation
- **Address handshake.** A request is accepted in a cycle where `req.valid & resp.ready`. The block latches `write`, the start index `addr[2 +: log2(DEPTH_WORDS)]` and the length. Length is 1 when `burst == 0` and `BURST_LEN` otherwise. Upper address bits and `addr[1:0]` are ignored, so aliasing is permitted.
- **Beat handshake.** A beat transfers in a cycle where `req.data_ok & resp.data_ok`.
- **Burst addressing.** Beat k uses index `{start[hi:log2(BURST_LEN)], (start[log2(BURST_LEN)-1:0] + k) mod BURST_LEN}`. This is critical-word-first, wrapping inside the `BURST_LEN`-aligned block. Single beats use `start`.
- **IDLE state.**
  - `ready = 1`, `data_ok = 0`, `data_last = 0`.
  - On accept with `write == 0`: issue the SRAM read of beat 0 in the same cycle (address taken combinationally from `req.addr`), then go to READ.
  - On accept with `write == 1`: go to WRITE.
- **READ state.**
  - `ready = 0`, `data_ok = 1`, `r_data` = the SRAM output for the current beat.
  - `data_last = 1` when the beat counter equals length-1.
  - On each beat transfer that is not last: issue the read for the next beat and increment the counter.
  - While `req.data_ok = 0`: no SRAM read is issued, and `r_data` and `data_last` hold stable.
  - On the last beat transfer: return to IDLE.
- **WRITE state.**
  - `ready = 0`, `data_ok = 1`, `r_data = 0`.
  - `data_last = 1` when the beat counter equals length-1.
  - On each beat transfer: write `w_data` to the beat index, with byte lanes enabled by `data_strobe[3:0]`, then increment the counter.
  - On the last beat transfer: return to IDLE.
  - `req.data_last` is not used for termination; termination is by count only.
- **Beat counter.** Width is log2(`BURST_LEN`) + 1. It clears on every accept.
- **Same-cycle request after completion.** A request presented in the cycle of a final-beat transfer is not accepted, because `ready = 0`. It is accepted in the next cycle.
- **Reset.** Reset returns the block to IDLE from any state and discards any in-flight transaction. SRAM contents are not cleared.

## Timing
- **Reset values.** While `rst_n == 0`: `ready = 0`, `data_ok = 0`, `data_last = 0`, `r_data = 0`, state = IDLE, counter = 0. `ready = 1` from the first cycle after reset is released.
- **Read latency.** The address handshake at cycle T gives `data_ok = 1` with beat 0 valid at T+1.
- **Read throughput.** With `req.data_ok` held high, one beat per cycle. A burst accepted at T completes at T+`BURST_LEN`.
- **Write timing.** Write data is accepted from T+1, one beat per cycle when `req.data_ok` is high. Each write is committed at the clock edge of its beat transfer.
- **Return to idle.** If the final beat transfers at cycle L, then `ready = 1` at L+1. The minimum request-to-request spacing is length+1 cycles.
- **Read-after-write.** A read whose handshake falls at L+1 after a write ending at L returns the new data.
- **Pipelining.** The block never has more than one outstanding transaction. There is no address pipelining.

## Configuration
- **Macro:** `CACHE_BUS_RESP_WRITE_EN`.
- **Defined:** write transactions update the SRAM as described under WRITE state.
- **Undefined:**
  - WRITE-state handshaking, counting and `data_last` are unchanged, so initiators never hang.
  - `w_data` is discarded and the SRAM write port is removed (ROM behaviour).
  - SRAM contents come only from the initialization file.

## Test plan
- **Single read.** Preload word 0x40 = 0xDEADBEEF. Request `addr = 0x100`, `burst = 0`, `req.data_ok = 1`. Expect `data_ok` and `data_last` high one cycle after the handshake, `r_data = 0xDEADBEEF`, and `ready = 1` on the next cycle.
- **Wrapping burst read.** `BURST_LEN = 8`, word i = i. Request `addr = 0x14`, `burst != 0`. Expect beats 5,6,7,0,1,2,3,4 on consecutive cycles, with `data_last` only on the beat with value 4.
- **Backpressure.** Same burst, with `req.data_ok` low on cycles 2–4 after the handshake. Expect `r_data` and `data_ok` held constant through the stall, no beat skipped or repeated, and completion delayed by 3 cycles.
- **Strobed write then read-back (macro defined).**
  - Word 0x10 = 0x11223344.
  - Single write to `addr = 0x40` with `w_data = 0xAABBCCDD`, `data_strobe = 4'b0101`.
  - Expect a read at L+1 to return 0x11BB33DD.
- **Reset mid-burst.** Assert `rst_n = 0` on beat 3 of a read burst. Expect all response fields 0 during reset and `ready = 1` one cycle after release. A new single read then returns correct data.
- **Macro undefined.** A write burst completes with `data_last` on beat 8 and `ready = 1` afterwards. A read-back returns the preloaded, unchanged values.
